// File: rtl/rsa_modexp_ctrl.sv
// Round-robin scheduler and right-to-left square-and-multiply sequencer that
// computes c^d mod n for two clients on one shared external modular multiplier.
module rsa_modexp_ctrl #(
  parameter int CW = 33,
  parameter int EW = 5,
  parameter int NW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*CW-1:0]   req_base,
  input  logic [2*EW-1:0]   req_exp,
  input  logic [2*NW-1:0]   req_mod,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [NW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic              mm_req,
  output logic [NW-1:0]     mm_a,
  output logic [NW-1:0]     mm_b,
  output logic [NW-1:0]     mm_n,
  input  logic              mm_ack,
  input  logic [NW-1:0]     mm_p
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_SQR,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            any_req;
  logic            gnt_id;
  logic            last_gnt;
  logic            gid;
  logic [CW-1:0]   base_in_r;
  logic [NW-1:0]   base_r;
  logic [NW-1:0]   res_r;
  logic [NW-1:0]   n_r;
  logic [EW-1:0]   exp_r;
  logic            err_r;

  // Wide base reduced once up front so every multiplier operand fits NW bits.
  function automatic logic [NW-1:0] reduce_base(input logic [CW-1:0] b,
                                                input logic [NW-1:0] n);
    logic [CW-1:0] q;
    q = '0;
    if (n != '0) q = b % CW'(n);
    return q[NW-1:0];
  endfunction

  // Accumulator seed: 1 mod n, forced to 0 for n==1 and for the n==0 error.
  function automatic logic [NW-1:0] seed_res(input logic [NW-1:0] n);
    return (n <= NW'(1)) ? '0 : NW'(1);
  endfunction

  assign any_req = |req_valid;
  assign gnt_id  = (&req_valid) ? ~last_gnt : req_valid[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == S_RESP && rsp_ready) last_gnt <= gid;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    mm_req    = 1'b0;
    mm_a      = '0;
    mm_b      = '0;
    mm_n      = '0;
    case (state)
      S_IDLE: begin
        if (rst && any_req) begin
          req_ready = gnt_id ? 2'b10 : 2'b01;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (n_r == '0 || exp_r == '0) state_nxt = S_RESP;
        else if (exp_r[0])            state_nxt = S_MUL;
        else                          state_nxt = S_SQR;
      end
      S_MUL: begin
        mm_req = 1'b1;
        mm_a   = res_r;
        mm_b   = base_r;
        mm_n   = n_r;
        if (mm_ack) state_nxt = (exp_r[EW-1:1] == '0) ? S_RESP : S_SQR;
      end
      S_SQR: begin
        mm_req = 1'b1;
        mm_a   = base_r;
        mm_b   = base_r;
        mm_n   = n_r;
        // exp_r[1] is bit 0 of the exponent after this square's shift.
        if (mm_ack) state_nxt = exp_r[1] ? S_MUL : S_SQR;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = gid;
        rsp_data  = res_r;
        rsp_err   = err_r;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job datapath: outputs are gated by state, so these need no reset.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (any_req) begin
          gid       <= gnt_id;
          base_in_r <= gnt_id ? req_base[CW +: CW] : req_base[0 +: CW];
          exp_r     <= gnt_id ? req_exp[EW +: EW]  : req_exp[0 +: EW];
          n_r       <= gnt_id ? req_mod[NW +: NW]  : req_mod[0 +: NW];
        end
      end
      S_LOAD: begin
        base_r <= reduce_base(base_in_r, n_r);
        res_r  <= seed_res(n_r);
        err_r  <= (n_r == '0);
      end
      S_MUL: begin
        if (mm_ack) res_r <= mm_p;
      end
      S_SQR: begin
        if (mm_ack) begin
          base_r <= mm_p;
          exp_r  <= exp_r >> 1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: directed and randomized jobs against a plain
// arithmetic model of c^d mod n, op counts and round-robin order.
module tb_rsa_modexp_ctrl;

  localparam int CW = 33;
  localparam int EW = 5;
  localparam int NW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*CW-1:0]   req_base;
  logic [2*EW-1:0]   req_exp;
  logic [2*NW-1:0]   req_mod;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [NW-1:0]     rsp_data;
  logic              rsp_err;
  logic              mm_req;
  logic [NW-1:0]     mm_a;
  logic [NW-1:0]     mm_b;
  logic [NW-1:0]     mm_n;
  logic              mm_ack;
  logic [NW-1:0]     mm_p;

  rsa_modexp_ctrl #(.CW(CW), .EW(EW), .NW(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_base  (req_base),
    .req_exp   (req_exp),
    .req_mod   (req_mod),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mm_req    (mm_req),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_n      (mm_n),
    .mm_ack    (mm_ack),
    .mm_p      (mm_p)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int last_m = 1;
  int lat_lo = 1;
  int lat_hi = 1;
  int ops_cnt = 0;
  int mm_unstable = 0;
  int rst_count = 0;

  logic        pend_v [2];
  logic [32:0] pend_b [2];
  logic [4:0]  pend_e [2];
  logic [7:0]  pend_m [2];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: repeated multiplication, no bit scanning.
  function automatic longint m_exp(input longint unsigned b, input int e, input int m);
    longint unsigned r, bb;
    if (m == 0) return 0;
    bb = b % longint'(m);
    r  = 1 % longint'(m);
    for (int i = 0; i < e; i++) r = (r * bb) % longint'(m);
    return longint'(r);
  endfunction

  function automatic int m_ops(input int e, input int m);
    int pc, msb;
    pc = 0;
    msb = 0;
    if (e == 0 || m == 0) return 0;
    for (int i = 0; i < 32; i++)
      if (((e >> i) & 1) == 1) begin
        pc++;
        msb = i;
      end
    return pc + msb;
  endfunction

  // Modular multiplier with random latency; tracks operand stability.
  initial begin : mult
    int cnt, seen;
    bit pending, orphan;
    logic [7:0] ca, cb, cn;
    cnt = 0; seen = 0; pending = 0; orphan = 0;
    ca = '0; cb = '0; cn = '0;
    mm_ack = 1'b0;
    mm_p = '0;
    forever begin
      step();
      mm_ack = 1'b0;
      if (seen != rst_count) begin
        seen = rst_count;
        if (pending) orphan = 1;
      end
      if (pending) begin
        if (!orphan && (mm_req !== 1'b1 || mm_a !== ca || mm_b !== cb || mm_n !== cn))
          mm_unstable++;
        cnt--;
        if (cnt == 0) begin
          mm_ack = 1'b1;
          mm_p = 8'((int'(ca) * int'(cb)) % int'(cn));
          pending = 0;
        end
      end else if (mm_req === 1'b1 && rst === 1'b1) begin
        ca = mm_a; cb = mm_b; cn = mm_n;
        cnt = int'($urandom_range(lat_hi, lat_lo));
        pending = 1;
        orphan = 0;
        ops_cnt++;
      end
    end
  end

  task automatic post(input int c, input logic [32:0] b, input logic [4:0] e, input logic [7:0] m);
    pend_v[c] = 1'b1;
    pend_b[c] = b;
    pend_e[c] = e;
    pend_m[c] = m;
    req_base[c*CW +: CW] = b;
    req_exp[c*EW +: EW]  = e;
    req_mod[c*NW +: NW]  = m;
    req_valid[c] = 1'b1;
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id",    64'(rsp_id),    64'(0));
    chk("rst_rsp_data",  64'(rsp_data),  64'(0));
    chk("rst_rsp_err",   64'(rsp_err),   64'(0));
    chk("rst_mm_req",    64'(mm_req),    64'(0));
    chk("rst_mm_a",      64'(mm_a),      64'(0));
    chk("rst_mm_b",      64'(mm_b),      64'(0));
    chk("rst_mm_n",      64'(mm_n),      64'(0));
  endtask

  // Waits for the predicted grant, then follows the job to its response.
  task automatic serve(input int hold);
    int gx, n, cyc, ops0, e_ops;
    logic [7:0] e_data;
    logic e_err;
    logic [63:0] snap;
    #1;
    if (pend_v[0] && pend_v[1]) gx = (last_m == 1) ? 0 : 1;
    else                        gx = pend_v[1] ? 1 : 0;
    rsp_ready = (hold == 0);
    n = 0;
    while (req_ready == 2'b00 && n < 100) begin step(); n++; end
    chk("grant", 64'(req_ready), 64'(2'b01 << gx));
    if (req_ready == 2'b00) return;
    ops0   = ops_cnt;
    e_data = 8'(m_exp(64'(pend_b[gx]), int'(pend_e[gx]), int'(pend_m[gx])));
    e_err  = (pend_m[gx] == 8'd0);
    e_ops  = m_ops(int'(pend_e[gx]), int'(pend_m[gx]));
    step();
    cyc = 1;
    req_valid[gx] = 1'b0;
    pend_v[gx] = 1'b0;
    while (rsp_valid !== 1'b1 && cyc < 600) begin step(); cyc++; end
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rsp_id",    64'(rsp_id),    64'(gx));
    chk("rsp_data",  64'(rsp_data),  64'(e_data));
    chk("rsp_err",   64'(rsp_err),   64'(e_err));
    chk("mm_ops",    64'(ops_cnt - ops0), 64'(e_ops));
    chk("no_grant_resp", 64'(req_ready), 64'(0));
    if (lat_hi == 1) chk("latency", 64'(cyc), 64'(2 + 2 * e_ops));
    snap = 64'({rsp_valid, rsp_id, rsp_err, rsp_data});
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rsp_hold", 64'({rsp_valid, rsp_id, rsp_err, rsp_data}), snap);
      chk("no_grant_busy", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    step();
    chk("rsp_drop", 64'(rsp_valid), 64'(0));
    chk("mm_stable", 64'(mm_unstable), 64'(0));
    last_m = gx;
  endtask

  initial begin : main
    int c, n, rm, hold;
    logic [32:0] rb;
    rst = 1'b0;
    req_valid = '0;
    req_base = '0;
    req_exp = '0;
    req_mod = '0;
    rsp_ready = 1'b1;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    repeat (3) step();
    chk_reset();
    rst = 1'b1;

    // Client 1 alone, single-cycle multiplier.
    post(1, 33'd31, 5'd7, 8'd33);
    serve(0);

    // Contention: client 0 first, then client 1 wins the next contention.
    post(0, 33'd4, 5'd3, 8'd33);
    post(1, 33'd31, 5'd7, 8'd33);
    serve(0);
    post(0, 33'd4, 5'd3, 8'd33);
    serve(0);
    serve(0);

    // Wide base reduction and edge cases.
    post(0, 33'h1_0000_0000, 5'd1, 8'd33);
    serve(0);
    post(1, 33'd9, 5'd0, 8'd33);
    serve(0);
    post(0, 33'd200, 5'd5, 8'd1);
    serve(0);
    post(1, 33'd17, 5'd9, 8'd0);
    serve(0);

    // Backpressure with random multiplier latency and a waiting requester.
    lat_lo = 1;
    lat_hi = 6;
    post(0, 33'd4, 5'd3, 8'd33);
    post(1, 33'd31, 5'd7, 8'd33);
    serve(10);
    serve(0);

    // Reset during a square; the late ack must be ignored.
    lat_lo = 6;
    lat_hi = 6;
    post(1, 33'd5, 5'd4, 8'd33);
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 100) begin step(); n++; end
    chk("rst_job_grant", 64'(req_ready), 64'(2'b10));
    step();
    req_valid[1] = 1'b0;
    pend_v[1] = 1'b0;
    n = 0;
    while (mm_req !== 1'b1 && n < 50) begin step(); n++; end
    chk("rst_job_sqr", 64'({mm_req, mm_a, mm_b}), 64'({1'b1, 8'd5, 8'd5}));
    step();
    step();
    rst = 1'b0;
    rst_count++;
    step();
    rst = 1'b1;
    last_m = 1;
    chk_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_quiet", 64'({mm_req, rsp_valid, req_ready}), 64'(0));
    end
    lat_lo = 1;
    lat_hi = 6;
    post(0, 33'd7, 5'd13, 8'd97);
    serve(0);

    // Randomized jobs.
    for (int k = 0; k < 25; k++) begin
      c  = int'($urandom_range(1, 0));
      rb = {1'($urandom), 32'($urandom)};
      rm = int'($urandom_range(255, 0));
      if ($urandom_range(7, 0) == 0) rm = int'($urandom_range(1, 0));
      post(c, rb, 5'($urandom_range(31, 0)), 8'(rm));
      if ($urandom_range(3, 0) == 0)
        post(1 - c, {1'($urandom), 32'($urandom)}, 5'($urandom_range(31, 0)),
             8'($urandom_range(255, 2)));
      hold = int'($urandom_range(3, 0));
      serve(hold);
      while (pend_v[0] || pend_v[1]) serve(int'($urandom_range(2, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
Scheduler and sequencer for modular exponentiation (m = c^d mod n) on one shared external modular multiplier. Two requesters share it: client 0 (encrypt path) and client 1 (decrypt path), with round-robin arbitration between them. Exponentiation runs right-to-left square-and-multiply, one multiplier operation at a time. Sits between the encrypt/decrypt front ends and the multiplier, so neither front end needs a wide combinational power operator.

Parameters:
CW, 33, base/ciphertext width per client
EW, 5, exponent width per client
NW, 8, modulus, multiplier-operand and result width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  2  bit i = client i has a request
req_ready  out  2  bit i = client i request accepted this cycle (one-cycle pulse)
req_base  in  2*CW  client i base at [i*CW +: CW]
req_exp  in  2*EW  client i exponent at [i*EW +: EW]
req_mod  in  2*NW  client i modulus at [i*NW +: NW]
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  client that owns the result
rsp_data  out  NW  c^d mod n
rsp_err  out  1  request had n == 0
mm_req  out  1  multiply request, held until mm_ack
mm_a  out  NW  operand a
mm_b  out  NW  operand b
mm_n  out  NW  modulus
mm_ack  in  1  one-cycle pulse, mm_p valid; earliest the cycle after mm_req rises
mm_p  in  NW  (a*b) mod n

Behaviour:
- Reset (rst==0 at clock edge): state IDLE; req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, mm_req=0, mm_a/mm_b/mm_n=0. Round-robin pointer gives client 0 priority. Reset mid-operation abandons the job. A late mm_ack after reset is ignored.
- Internal registers: gid, base_r[NW], res_r[NW], exp_r[EW], n_r[NW], last grant.
- IDLE: if any req_valid, grant a client. Both valid: the client not served last wins. Only one valid: that client wins. Pulse req_ready[g] in this cycle and capture its base/exp/mod. Next state LOAD.
- LOAD (1 cycle): base_r = base mod n_r; res_r = (n_r==1) ? 0 : 1; exp_r = exp.
  - n_r==0: set rsp_err=1, rsp_data=0, go to RESP.
  - exp==0: go to RESP with res_r.
  - Otherwise go to MUL if exp[0]=1, else SQR.
- MUL: mm_req=1, mm_a=res_r, mm_b=base_r, mm_n=n_r. On mm_ack: res_r=mm_p. Then go to RESP if (exp_r>>1)==0, else SQR.
- SQR: mm_req=1, mm_a=mm_b=base_r. On mm_ack: base_r=mm_p, exp_r=exp_r>>1. Then go to MUL if new exp_r[0]=1, else SQR.
- The final squaring after the top set bit is never issued. Multiplier ops per job = popcount(d) + (index of MSB set).
- mm_a/mm_b/mm_n stay stable while mm_req=1. mm_req drops the cycle after mm_ack. Never more than one outstanding op.
- RESP: rsp_valid=1 with rsp_id=gid, rsp_data=res_r, rsp_err. Hold all stable until rsp_ready=1. On the handshake, clear rsp_valid, update the round-robin pointer to gid, and go to IDLE. No new request is granted in the handshake cycle.
- A new request is not accepted while busy. req_valid may stay high and is granted later. A request withdrawn before its grant is simply not served.
- Latency with 1-cycle multiplier: accept + LOAD + 2 cycles per op, then rsp_valid.

Test Plan:
- Client 1 alone, base=31, exp=7, mod=33, 1-cycle multiplier -> exactly 5 mm ops (MUL,SQR,MUL,SQR,MUL), rsp_id=1, rsp_data=4, rsp_err=0, rsp_valid on cycle 12 after acceptance.
- Both valid same cycle after reset: client0 (4,3,33), client1 (31,7,33) -> client0 served first with rsp_data=31, then client1 with 4. Repeat the pair -> client1 first this time (round-robin).
- Base reduction: base=33'h1_0000_0000, exp=1, mod=33 -> rsp_data=4, one MUL, no SQR.
- Edge cases:
  - exp=0, mod=33 -> rsp_data=1, zero mm ops.
  - mod=1, exp=5 -> rsp_data=0.
  - mod=0 -> rsp_err=1, rsp_data=0, zero mm ops.
- Backpressure and random multiplier latency 1-6 cycles: hold rsp_ready=0 for 10 cycles -> rsp outputs stable, no req_ready pulse. mm operands stable while mm_req=1 and results unchanged.
- Assert rst=0 for one cycle during SQR -> all outputs at reset values next cycle. A subsequent mm_ack is ignored. The next request completes correctly.
